button_encoder: RTL and testbench
=================================

Name: button_encoder

Overview:
- Front end that turns the four raw colour push-buttons into the encoded key stream the game controller consumes.
- Synchronises and debounces the buttons, rejects chords, and encodes a single pressed button to a 2-bit colour code.
- Emits exactly one KEY_VALID pulse per physical press and waits for full release before accepting the next press.
- Sits between the board pins and the controller's IN/IN_VALID inputs.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before the debounced vector updates (minimum 2).
CNT_W, $clog2(DEBOUNCE_CYCLES)+1, width of the debounce counter.

Ports:
CLK  input  1  system clock
RST  input  1  synchronous reset, active-high
BTN  input  4  raw asynchronous buttons, one per colour, active-high
ENABLE  input  1  controller is accepting input; presses made while low are swallowed
KEY  output  2  encoded colour of the last accepted press
KEY_VALID  output  1  one-cycle pulse, KEY is valid
BUSY  output  1  high while a press is held (state HELD)

Behaviour:
- One clock, CLK; reset is synchronous and active-high on RST. All flops clear on RST: sync stages, sync_d, db_vec, cnt = 0; KEY = 0, KEY_VALID = 0, BUSY = 0; state = IDLE.
- Reset asserted mid-press: FSM goes to IDLE and db_vec goes to 0.
  - If the button is still held after reset, it is seen as a new press once it has been stable for the debounce window. This is intended.
- Sync: two-flop synchroniser per bit gives sync_vec. sync_d is sync_vec delayed one cycle.
- Debounce (vector-wide), evaluated in this order:
  - sync_vec != sync_d: cnt <= 0.
  - else if sync_vec == db_vec: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: db_vec <= sync_vec, cnt <= 0.
  - else cnt <= cnt+1.
- Encode: BTN[0]->2'd0, BTN[1]->2'd1, BTN[2]->2'd2, BTN[3]->2'd3.
- FSM states IDLE, HELD:
  - IDLE, db_vec == 0: stay.
  - IDLE, db_vec one-hot and ENABLE: KEY <= encode(db_vec), KEY_VALID <= 1 for one cycle, go to HELD.
  - IDLE, db_vec one-hot and !ENABLE: go to HELD with no pulse (press swallowed).
  - IDLE, db_vec multi-hot: go to HELD with no pulse (chord rejected).
  - HELD: stay until db_vec == 0, then go to IDLE. Adding or changing buttons while in HELD never produces a pulse.
- KEY_VALID is registered and high for exactly one cycle per accepted press.
- KEY holds its value after the pulse; it is not cleared.
- BUSY = (state == HELD), registered.
- Latency: raw BTN settles before clock edge 1 -> db_vec updates at edge DEBOUNCE_CYCLES+3 -> KEY_VALID is high after edge DEBOUNCE_CYCLES+4.
  - With the default of 4, that is edges 7 and 8.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES+1 cycles never reaches db_vec.
- Release goes through the same debounce. The next press is accepted only after release has been stable for the full window.
- ENABLE is sampled only in IDLE, in the cycle the press is recognised. ENABLE falling during HELD has no effect.

Decomposition:
- Shared constants include: the colour code values (shared with the controller) and the FSM state encodings.
- Sub-module btn_debounce holds the synchroniser, sync_d, cnt and db_vec. It is parameterised by DEBOUNCE_CYCLES and outputs the 4-bit db_vec.
- The top level holds the encode logic and the FSM.

Test Plan:
- Clean press: ENABLE=1, RST released, BTN=4'b0100 held 20 cycles then 0 -> KEY_VALID high for exactly 1 cycle, after edge 8; KEY=2'd2; BUSY high until release is debounced; no second pulse.
- Bounce: BTN toggles 0100/0000 every 2 cycles for 10 cycles, then stable 0100 -> exactly one pulse with KEY=2, 8 edges after the last toggle.
- Chord: BTN=4'b0011 held 20 cycles, then 0 -> no KEY_VALID, BUSY high; a following single press of BTN[3] -> KEY=3 with one pulse.
- Hold then add: BTN=0001 (pulse, KEY=0), then add BTN[2] while held -> no additional pulse; release all -> IDLE.
- Disabled: ENABLE=0 during BTN=1000 press -> no pulse; ENABLE=1 with button still held -> still no pulse; release and re-press -> pulse with KEY=3.
- Reset mid-press: RST asserted for 1 cycle while BTN=0010 is held in HELD -> outputs 0, state IDLE; button kept held -> pulse with KEY=1, DEBOUNCE_CYCLES+4 cycles after RST deasserts.

Source files
------------

// File: rtl/button_encoder_pkg.sv
// button_encoder_pkg: colour codes, FSM states and encode helpers shared with the game controller.
package button_encoder_pkg;
   localparam int NUM_BTN = 4;
   localparam logic [1:0] CODE_B0 = 2'd0;
   localparam logic [1:0] CODE_B1 = 2'd1;
   localparam logic [1:0] CODE_B2 = 2'd2;
   localparam logic [1:0] CODE_B3 = 2'd3;
   typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;
   function automatic logic [1:0] encode(input logic [NUM_BTN-1:0] v);
      return v[3] ? CODE_B3 : v[2] ? CODE_B2 : v[1] ? CODE_B1 : CODE_B0;
   endfunction
   function automatic logic is_onehot(input logic [NUM_BTN-1:0] v);
      return (v != '0) && ((v & (v - 4'd1)) == '0);
   endfunction
endpackage

// File: rtl/button_encoder_btn_debounce.sv
// btn_debounce: two-flop synchroniser plus vector-wide debounce of the raw buttons.
module btn_debounce
   import button_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn,
   output logic [NUM_BTN-1:0] db_vec
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic [NUM_BTN-1:0] sync_meta, sync_vec, sync_d;
   logic [CNT_W-1:0]   cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_meta <= '0;
         sync_vec  <= '0;
         sync_d    <= '0;
         db_vec    <= '0;
         cnt       <= '0;
      end else begin
         sync_meta <= btn;
         sync_vec  <= sync_meta;
         sync_d    <= sync_vec;
         // any movement, or agreement with the output, restarts the stability window
         if (sync_vec != sync_d || sync_vec == db_vec) cnt <= '0;
         else if (cnt == LAST) begin
            db_vec <= sync_vec;
            cnt    <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/button_encoder.sv
// button_encoder: debounced, chord-rejecting encoder emitting one KEY_VALID pulse per press.
module button_encoder
   import button_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_BTN-1:0] BTN,
   input  logic               ENABLE,
   output logic [1:0]         KEY,
   output logic               KEY_VALID,
   output logic               BUSY
);
   logic [NUM_BTN-1:0] db_vec;
   state_t             state;
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(CLK), .rst(RST), .btn(BTN), .db_vec(db_vec)
   );
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         KEY       <= '0;
         KEY_VALID <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         KEY_VALID <= 1'b0;
         if (state == IDLE) begin
            // swallowed presses and chords still park in HELD until full release
            if (db_vec != '0) begin
               state <= HELD;
               BUSY  <= 1'b1;
               if (is_onehot(db_vec) && ENABLE) begin
                  KEY       <= encode(db_vec);
                  KEY_VALID <= 1'b1;
               end
            end
         end else if (db_vec == '0) begin
            state <= IDLE;
            BUSY  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_button_encoder.sv
// tb_button_encoder: directed table of press phases plus hand sequences for latency, bounce and reset.
module tb_button_encoder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn = 4'b0;
   logic       enable = 1'b1;
   logic [1:0] key;
   logic       key_valid, busy;
   int checks = 0;
   int errors = 0;
   typedef struct {
      logic [3:0] btn;
      logic       en;
      int         n;
      int         pulses;
      logic [1:0] key;
      logic       busy;
      string      name;
   } vec_t;
   vec_t tbl[16];
   always #5 clk = ~clk;
   button_encoder dut (
      .CLK(clk), .RST(rst), .BTN(btn), .ENABLE(enable),
      .KEY(key), .KEY_VALID(key_valid), .BUSY(busy)
   );
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic run(input int n, output int p);
      p = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (key_valid) p++;
      end
   endtask
   task automatic pulse_at(input int exp_edge, input string nm);
      int first = -1;
      int cnt = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (key_valid) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      chk({nm, " pulse edge"}, first, exp_edge);
      chk({nm, " pulse count"}, cnt, 1);
   endtask
   initial begin
      int p;
      tbl[0]  = '{4'b0011, 1'b1, 20, 0, 2'd2, 1'b1, "chord held"};
      tbl[1]  = '{4'b0000, 1'b1, 20, 0, 2'd2, 1'b0, "chord release"};
      tbl[2]  = '{4'b1000, 1'b1, 20, 1, 2'd3, 1'b1, "after chord b3"};
      tbl[3]  = '{4'b0000, 1'b1, 20, 0, 2'd3, 1'b0, "b3 release"};
      tbl[4]  = '{4'b0001, 1'b1, 20, 1, 2'd0, 1'b1, "b0 press"};
      tbl[5]  = '{4'b0101, 1'b1, 20, 0, 2'd0, 1'b1, "add b2 held"};
      tbl[6]  = '{4'b0000, 1'b1, 20, 0, 2'd0, 1'b0, "release all"};
      tbl[7]  = '{4'b1000, 1'b0, 20, 0, 2'd0, 1'b1, "disabled b3"};
      tbl[8]  = '{4'b1000, 1'b1, 20, 0, 2'd0, 1'b1, "enable while held"};
      tbl[9]  = '{4'b0000, 1'b1, 20, 0, 2'd0, 1'b0, "disabled release"};
      tbl[10] = '{4'b1000, 1'b1, 20, 1, 2'd3, 1'b1, "re-press b3"};
      tbl[11] = '{4'b0000, 1'b1, 20, 0, 2'd3, 1'b0, "re-press release"};
      tbl[12] = '{4'b0010, 1'b1, 20, 1, 2'd1, 1'b1, "b1 press"};
      tbl[13] = '{4'b0010, 1'b0, 20, 0, 2'd1, 1'b1, "enable drop in held"};
      tbl[14] = '{4'b0000, 1'b0, 20, 0, 2'd1, 1'b0, "b1 release"};
      tbl[15] = '{4'b0100, 1'b0, 20, 0, 2'd1, 1'b1, "disabled b2"};
      repeat (3) @(posedge clk);
      #1;
      chk("reset key", int'(key), 0);
      chk("reset key_valid", int'(key_valid), 0);
      chk("reset busy", int'(busy), 0);
      rst = 1'b0;
      run(4, p);
      chk("idle no pulse", p, 0);
      btn = 4'b0100;
      pulse_at(8, "clean press");
      chk("clean key", int'(key), 2);
      run(8, p);
      chk("clean no repeat", p, 0);
      chk("clean busy", int'(busy), 1);
      btn = 4'b0000;
      run(6, p);
      chk("busy before release debounced", int'(busy), 1);
      run(14, p);
      chk("clean released busy", int'(busy), 0);
      chk("clean release pulses", p, 0);
      for (int i = 0; i < 6; i++) begin
         btn = i[0] ? 4'b0000 : 4'b0100;
         run(2, p);
         chk("bounce no pulse", p, 0);
      end
      btn = 4'b0100;
      pulse_at(8, "bounce");
      chk("bounce key", int'(key), 2);
      btn = 4'b0000;
      run(20, p);
      chk("bounce release busy", int'(busy), 0);
      for (int i = 0; i < 16; i++) begin
         btn = tbl[i].btn;
         enable = tbl[i].en;
         run(tbl[i].n, p);
         chk({tbl[i].name, " pulses"}, p, tbl[i].pulses);
         chk({tbl[i].name, " key"}, int'(key), int'(tbl[i].key));
         chk({tbl[i].name, " busy"}, int'(busy), int'(tbl[i].busy));
      end
      btn = 4'b0000;
      enable = 1'b1;
      run(20, p);
      chk("pre-reset idle", int'(busy), 0);
      btn = 4'b0010;
      run(15, p);
      chk("mid-press pulse", p, 1);
      chk("mid-press busy", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid reset key", int'(key), 0);
      chk("mid reset key_valid", int'(key_valid), 0);
      chk("mid reset busy", int'(busy), 0);
      rst = 1'b0;
      pulse_at(8, "post-reset held");
      chk("post-reset key", int'(key), 1);
      btn = 4'b0000;
      run(20, p);
      chk("final release busy", int'(busy), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
